// File: rtl/mem_access_unit.sv
// ---------------------------------------------------------------------------
// mem_access_unit
//   MEM pipeline stage with a registered request/acknowledge data-memory bus
//   and the MEM/WB pipeline register.
//   Each aligned load or store issues one bus request. The unit then waits for
//   bus_ack or gives up after TIMEOUT cycles. It stalls the upstream pipeline
//   while the access is in flight.
//
// Ports
//   clk, reset              clock, asynchronous active-high reset
//   MEM_*                   EX/MEM pipeline register contents (inputs)
//   bus_req/we/addr/wdata   registered request to data memory (outputs)
//   bus_rdata, bus_ack      read data and one-cycle completion strobe (inputs)
//   mem_stall               combinational hold for PC, IF/ID, ID/EX, EX/MEM
//   WB_*                    MEM/WB pipeline register (outputs)
//   err_misalign/timeout    sticky error flags, cleared only by reset
// ---------------------------------------------------------------------------
module mem_access_unit #(
  parameter logic [7:0] TIMEOUT = 8'd255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MEM_MemRead,
  input  logic        MEM_MemWrite,
  input  logic        MEM_RegWrite,
  input  logic [1:0]  MEM_MemtoReg,
  input  logic [31:0] MEM_ALUout,
  input  logic [31:0] MEM_MUX1,
  input  logic [31:0] MEM_PC4,
  input  logic [4:0]  MEM_Write_register,
  input  logic [7:0]  MEM_Inst_Addr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ack,
  output logic        mem_stall,
  output logic        WB_RegWrite,
  output logic [1:0]  WB_MemtoReg,
  output logic [4:0]  WB_Write_register,
  output logic [31:0] WB_ALUout,
  output logic [31:0] WB_PC4,
  output logic [31:0] WB_MemData,
  output logic [7:0]  WB_Inst_Addr,
  output logic        err_misalign,
  output logic        err_timeout
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic        w_stall;
  logic        w_access;
  logic        w_aligned;
  logic        w_start;
  logic        w_misaligned;

  logic [7:0]  r_wait_cnt;
  logic [31:0] r_data;
  logic        r_bus_req;
  logic        r_bus_we;
  logic [31:0] r_bus_addr;
  logic [31:0] r_bus_wdata;
  logic        r_wb_regwrite;
  logic [1:0]  r_wb_memtoreg;
  logic [4:0]  r_wb_write_register;
  logic [31:0] r_wb_aluout;
  logic [31:0] r_wb_pc4;
  logic [31:0] r_wb_memdata;
  logic [7:0]  r_wb_inst_addr;
  logic        r_err_misalign;
  logic        r_err_timeout;

  assign w_access     = MEM_MemRead | MEM_MemWrite;
  assign w_aligned    = (MEM_ALUout[1:0] == 2'b00);
  assign w_start      = (r_state == S_IDLE) && w_access && w_aligned;
  assign w_misaligned = (r_state == S_IDLE) && w_access && !w_aligned;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and stall
  always_comb begin
    w_state_next = r_state;
    w_stall      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_access && w_aligned) begin
          w_stall      = 1'b1;
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        w_stall = 1'b1;
        if (bus_ack || (r_wait_cnt == TIMEOUT)) begin
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Bus request, wait counter, data latch and timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_req     <= 1'b0;
      r_bus_we      <= 1'b0;
      r_bus_addr    <= 32'd0;
      r_bus_wdata   <= 32'd0;
      r_wait_cnt    <= 8'd0;
      r_data        <= 32'd0;
      r_err_timeout <= 1'b0;
    end else begin
      if (w_start) begin
        // A simultaneous read+write request is treated as a write
        r_bus_req   <= 1'b1;
        r_bus_we    <= MEM_MemWrite;
        r_bus_addr  <= MEM_ALUout;
        r_bus_wdata <= MEM_MUX1;
        r_wait_cnt  <= 8'd0;
      end else if (r_state == S_WAIT) begin
        if (bus_ack) begin
          r_data    <= bus_rdata;
          r_bus_req <= 1'b0;
        end else if (r_wait_cnt == TIMEOUT) begin
          // Abandoned access: a recognisable poison value goes to writeback
          r_bus_req     <= 1'b0;
          r_data        <= 32'hDEADBEEF;
          r_err_timeout <= 1'b1;
        end else begin
          r_wait_cnt <= r_wait_cnt + 8'd1;
        end
      end
    end
  end

  // MEM/WB register and misalignment flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wb_regwrite       <= 1'b0;
      r_wb_memtoreg       <= 2'd0;
      r_wb_write_register <= 5'd0;
      r_wb_aluout         <= 32'd0;
      r_wb_pc4            <= 32'd0;
      r_wb_memdata        <= 32'd0;
      r_wb_inst_addr      <= 8'd0;
      r_err_misalign      <= 1'b0;
    end else if (w_stall) begin
      // Bubble: only the write enable is cleared, payload fields hold
      r_wb_regwrite <= 1'b0;
    end else begin
      // Not stalled means IDLE (no/misaligned access) or DONE
      r_wb_regwrite       <= MEM_RegWrite & ~w_misaligned;
      r_wb_memtoreg       <= MEM_MemtoReg;
      r_wb_write_register <= MEM_Write_register;
      r_wb_aluout         <= MEM_ALUout;
      r_wb_pc4            <= MEM_PC4;
      r_wb_inst_addr      <= MEM_Inst_Addr;
      r_wb_memdata        <= (r_state == S_DONE) ? r_data : 32'd0;
      if (w_misaligned) begin
        r_err_misalign <= 1'b1;
      end
    end
  end

  assign mem_stall         = w_stall;
  assign bus_req           = r_bus_req;
  assign bus_we            = r_bus_we;
  assign bus_addr          = r_bus_addr;
  assign bus_wdata         = r_bus_wdata;
  assign WB_RegWrite       = r_wb_regwrite;
  assign WB_MemtoReg       = r_wb_memtoreg;
  assign WB_Write_register = r_wb_write_register;
  assign WB_ALUout         = r_wb_aluout;
  assign WB_PC4            = r_wb_pc4;
  assign WB_MemData        = r_wb_memdata;
  assign WB_Inst_Addr      = r_wb_inst_addr;
  assign err_misalign      = r_err_misalign;
  assign err_timeout       = r_err_timeout;

endmodule

// File: tb/tb_mem_access_unit.sv
// ---------------------------------------------------------------------------
// tb_mem_access_unit
//   Directed testbench for mem_access_unit. A short TIMEOUT keeps the
//   timeout case brief. Bus acknowledge is driven by hand at a chosen
//   WAIT cycle. Every expected value below is hand-computed.
// ---------------------------------------------------------------------------
module tb_mem_access_unit;

  localparam logic [7:0] TMO = 8'd10;

  logic        clk;
  logic        reset;
  logic        MEM_MemRead, MEM_MemWrite, MEM_RegWrite;
  logic [1:0]  MEM_MemtoReg;
  logic [31:0] MEM_ALUout, MEM_MUX1, MEM_PC4;
  logic [4:0]  MEM_Write_register;
  logic [7:0]  MEM_Inst_Addr;
  logic        bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic        bus_ack;
  logic        mem_stall;
  logic        WB_RegWrite;
  logic [1:0]  WB_MemtoReg;
  logic [4:0]  WB_Write_register;
  logic [31:0] WB_ALUout, WB_PC4, WB_MemData;
  logic [7:0]  WB_Inst_Addr;
  logic        err_misalign, err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int st, rq, we;

  mem_access_unit #(.TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset),
    .MEM_MemRead(MEM_MemRead), .MEM_MemWrite(MEM_MemWrite),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemtoReg(MEM_MemtoReg),
    .MEM_ALUout(MEM_ALUout), .MEM_MUX1(MEM_MUX1), .MEM_PC4(MEM_PC4),
    .MEM_Write_register(MEM_Write_register), .MEM_Inst_Addr(MEM_Inst_Addr),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_rdata(bus_rdata), .bus_ack(bus_ack),
    .mem_stall(mem_stall),
    .WB_RegWrite(WB_RegWrite), .WB_MemtoReg(WB_MemtoReg),
    .WB_Write_register(WB_Write_register), .WB_ALUout(WB_ALUout),
    .WB_PC4(WB_PC4), .WB_MemData(WB_MemData), .WB_Inst_Addr(WB_Inst_Addr),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_mem(input logic rd, input logic wr, input logic rw,
                         input logic [1:0] mtr, input logic [31:0] alu,
                         input logic [31:0] mux1, input logic [31:0] pc4,
                         input logic [4:0] wreg, input logic [7:0] tag);
    MEM_MemRead        = rd;
    MEM_MemWrite       = wr;
    MEM_RegWrite       = rw;
    MEM_MemtoReg       = mtr;
    MEM_ALUout         = alu;
    MEM_MUX1           = mux1;
    MEM_PC4            = pc4;
    MEM_Write_register = wreg;
    MEM_Inst_Addr      = tag;
  endtask

  // Runs from the IDLE cycle of an access until the first unstalled cycle
  // (DONE). bus_ack is raised in WAIT cycle number ack_after (0 = never).
  task automatic run_access(input int ack_after, input logic [31:0] rdata,
                            output int stall_cyc, output int req_cyc,
                            output int we_cyc);
    int k;
    stall_cyc = 0;
    req_cyc   = 0;
    we_cyc    = 0;
    k         = 0;
    for (int c = 0; c < 64; c++) begin
      #1;
      if (!mem_stall) break;
      stall_cyc++;
      if (bus_req) begin
        req_cyc++;
        k++;
        if (bus_we && (bus_wdata == MEM_MUX1) && (bus_addr == MEM_ALUout)) we_cyc++;
      end
      bus_ack   = (ack_after > 0) && (k == ack_after);
      bus_rdata = rdata;
      tick();
    end
    bus_ack = 1'b0;
  endtask

  initial begin
    reset     = 1'b1;
    bus_ack   = 1'b0;
    bus_rdata = 32'd0;
    set_mem(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 8'd0);
    #1;
    check_eq("rst_bus_req",   32'(bus_req),      32'd0);
    check_eq("rst_bus_addr",  bus_addr,          32'd0);
    check_eq("rst_wb_rw",     32'(WB_RegWrite),  32'd0);
    check_eq("rst_wb_mdata",  WB_MemData,        32'd0);
    check_eq("rst_err_mis",   32'(err_misalign), 32'd0);
    check_eq("rst_err_tmo",   32'(err_timeout),  32'd0);
    #11 reset = 1'b0;
    tick();

    // ALU op, load, ALU op back to back
    set_mem(1'b0, 1'b0, 1'b1, 2'd0, 32'h111, 32'd0, 32'h4, 5'd1, 8'd1);
    #1 check_eq("alu1_stall", 32'(mem_stall), 32'd0);
    tick();
    check_eq("alu1_wb_alu",  WB_ALUout,         32'h111);
    check_eq("alu1_wb_rw",   32'(WB_RegWrite),  32'd1);
    check_eq("alu1_wb_md",   WB_MemData,        32'd0);
    check_eq("alu1_wb_tag",  32'(WB_Inst_Addr), 32'd1);

    set_mem(1'b1, 1'b0, 1'b1, 2'd1, 32'h10, 32'd0, 32'h8, 5'd2, 8'd2);
    run_access(1, 32'hCAFEF00D, st, rq, we);
    check_eq("ld_stall_cyc", 32'(st),            32'd2);
    check_eq("ld_req_cyc",   32'(rq),            32'd1);
    check_eq("ld_done_req",  32'(bus_req),       32'd0);
    check_eq("ld_bubble_rw", 32'(WB_RegWrite),   32'd0);
    check_eq("ld_bubble_alu", WB_ALUout,         32'h111);
    tick();
    check_eq("ld_wb_md",     WB_MemData,        32'hCAFEF00D);
    check_eq("ld_wb_rw",     32'(WB_RegWrite),  32'd1);
    check_eq("ld_wb_alu",    WB_ALUout,         32'h10);
    check_eq("ld_wb_tag",    32'(WB_Inst_Addr), 32'd2);
    check_eq("ld_wb_pc4",    WB_PC4,            32'h8);

    set_mem(1'b0, 1'b0, 1'b1, 2'd0, 32'h222, 32'd0, 32'hC, 5'd3, 8'd3);
    #1 check_eq("alu2_stall", 32'(mem_stall), 32'd0);
    tick();
    check_eq("alu2_wb_alu",  WB_ALUout,         32'h222);
    check_eq("alu2_wb_md",   WB_MemData,        32'd0);
    check_eq("alu2_wb_tag",  32'(WB_Inst_Addr), 32'd3);

    // Store (read+write both high -> write), ack in the 5th WAIT cycle
    set_mem(1'b1, 1'b1, 1'b0, 2'd2, 32'h40, 32'h12345678, 32'h10, 5'd0, 8'd4);
    run_access(5, 32'hFFFFFFFF, st, rq, we);
    check_eq("st_stall_cyc", 32'(st),      32'd6);
    check_eq("st_req_cyc",   32'(rq),      32'd5);
    check_eq("st_we_cyc",    32'(we),      32'd5);
    check_eq("st_done_req",  32'(bus_req), 32'd0);
    tick();
    check_eq("st_wb_rw",     32'(WB_RegWrite),  32'd0);
    check_eq("st_wb_mtr",    32'(WB_MemtoReg),  32'd2);
    check_eq("st_wb_tag",    32'(WB_Inst_Addr), 32'd4);

    // Misaligned load
    set_mem(1'b1, 1'b0, 1'b1, 2'd1, 32'h13, 32'd0, 32'h14, 5'd6, 8'd5);
    #1;
    check_eq("mis_stall",    32'(mem_stall), 32'd0);
    check_eq("mis_req_pre",  32'(bus_req),   32'd0);
    tick();
    check_eq("mis_req",      32'(bus_req),      32'd0);
    check_eq("mis_wb_rw",    32'(WB_RegWrite),  32'd0);
    check_eq("mis_wb_alu",   WB_ALUout,         32'h13);
    check_eq("mis_err",      32'(err_misalign), 32'd1);
    check_eq("mis_err_tmo",  32'(err_timeout),  32'd0);
    set_mem(1'b0, 1'b0, 1'b1, 2'd0, 32'h333, 32'd0, 32'h18, 5'd7, 8'd6);
    tick();
    check_eq("mis_sticky",   32'(err_misalign), 32'd1);
    check_eq("alu3_wb_rw",   32'(WB_RegWrite),  32'd1);

    // Timed-out load
    set_mem(1'b1, 1'b0, 1'b1, 2'd1, 32'h20, 32'd0, 32'h1C, 5'd8, 8'd7);
    run_access(0, 32'h55555555, st, rq, we);
    check_eq("tmo_req_cyc",   32'(rq),      32'(TMO) + 32'd1);
    check_eq("tmo_stall_cyc", 32'(st),      32'(TMO) + 32'd2);
    check_eq("tmo_done_req",  32'(bus_req), 32'd0);
    tick();
    check_eq("tmo_wb_md",    WB_MemData,        32'hDEADBEEF);
    check_eq("tmo_wb_rw",    32'(WB_RegWrite),  32'd1);
    check_eq("tmo_err",      32'(err_timeout),  32'd1);
    check_eq("tmo_mis_keep", 32'(err_misalign), 32'd1);

    // Reset in the middle of WAIT, then a stray ack
    set_mem(1'b1, 1'b0, 1'b1, 2'd1, 32'h30, 32'd0, 32'h20, 5'd9, 8'd8);
    tick();
    check_eq("rw_req_wait",  32'(bus_req), 32'd1);
    #1;
    set_mem(1'b0, 1'b0, 1'b0, 2'd0, 32'd0, 32'd0, 32'd0, 5'd0, 8'd0);
    reset = 1'b1;
    #1;
    check_eq("rw_req",       32'(bus_req),      32'd0);
    check_eq("rw_addr",      bus_addr,          32'd0);
    check_eq("rw_wb_alu",    WB_ALUout,         32'd0);
    check_eq("rw_wb_md",     WB_MemData,        32'd0);
    check_eq("rw_wb_tag",    32'(WB_Inst_Addr), 32'd0);
    check_eq("rw_err_mis",   32'(err_misalign), 32'd0);
    check_eq("rw_err_tmo",   32'(err_timeout),  32'd0);
    check_eq("rw_stall",     32'(mem_stall),    32'd0);
    #1 reset = 1'b0;
    bus_ack   = 1'b1;
    bus_rdata = 32'hABCD1234;
    tick();
    bus_ack = 1'b0;
    check_eq("ack_ign_req",  32'(bus_req),   32'd0);
    check_eq("ack_ign_md",   WB_MemData,     32'd0);
    tick();
    check_eq("ack_ign_md2",  WB_MemData,     32'd0);
    check_eq("ack_ign_stall", 32'(mem_stall), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
